// File: rtl/controlador_deslocamento.sv
// controlador_deslocamento: MSB-first parallel-to-serial controller driving an external shift register
// Ports:
//   clock_i     rising-edge clock
//   reset_i     synchronous active-high reset
//   start_i     level-sampled request, accepted only in IDLE
//   data_in_i   parallel word captured on acceptance
//   ser_out_o   registered serial bit for the shift register
//   shift_en_o  registered shift strobe
//   busy_o      high from the cycle after acceptance through DONE
//   done_o      one-cycle end-of-transaction pulse
//   word_out_o  mirror of the data bits shifted so far
// Optional feature: define PARITY_EN to append an even-parity bit after the data bits.
module controlador_deslocamento #(
  parameter int WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             ser_out_o,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] word_out_o
);
  localparam int CW = $clog2(WIDTH + 2);
`ifdef PARITY_EN
  localparam int NSH = WIDTH + 1;
`else
  localparam int NSH = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST      = CW'(NSH - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             sen_q, sen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif
  // Outputs are computed one cycle ahead so that ser_out/shift_en are plain flops.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    sen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SHIFT;
        buf_d   = data_in_i;
        word_d  = '0;
        cnt_d   = '0;
        ser_d   = data_in_i[WIDTH-1];
        sen_d   = 1'b1;
        busy_d  = 1'b1;
`ifdef PARITY_EN
        par_d   = ^data_in_i;
`endif
      end
      SHIFT: begin
        buf_d = buf_q << 1;
        cnt_d = cnt_q + CW'(1);
        // The parity cycle (count == WIDTH) must not enter the word mirror.
        if (cnt_q < CW'(WIDTH)) word_d = {word_q[WIDTH-2:0], ser_q};
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          sen_d = 1'b1;
`ifdef PARITY_EN
          ser_d = (cnt_q == LAST_DATA) ? par_q : buf_q[WIDTH-2];
`else
          ser_d = buf_q[WIDTH-2];
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign ser_out_o  = ser_q;
  assign shift_en_o = sen_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word_out_o = word_q;
endmodule

// File: tb/tb_controlador_deslocamento.sv
// tb_controlador_deslocamento: scoreboard bench for controlador_deslocamento
module tb_controlador_deslocamento;
  localparam int W = 4;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int P = NB + 2;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] din;
  logic         ser_out, shift_en, busy, done;
  logic [W-1:0] word_out;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  logic         exp_bits[$];
  logic [W-1:0] exp_words[$];
  controlador_deslocamento #(.WIDTH(W)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .data_in_i(din),
    .ser_out_o(ser_out), .shift_en_o(shift_en), .busy_o(busy),
    .done_o(done), .word_out_o(word_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_txn(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
`ifdef PARITY_EN
    exp_bits.push_back(^d);
`endif
    exp_words.push_back(d);
  endtask
  task automatic run_txn(input logic [W-1:0] d, input bit meddle);
    push_txn(d);
    start = 1'b1;
    din = d;
    step();
    start = meddle;
    if (meddle) din = '1;
    for (int i = 0; i < NB; i++) begin
      chk("shift_en_in_shift", shift_en, 1);
      chk("busy_in_shift", busy, 1);
      chk("done_in_shift", done, 0);
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("shift_en_in_done", shift_en, 0);
    chk("word_at_done", word_out, d);
    step();
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
    chk("word_hold", word_out, d);
  endtask
  // Serial bits and final words are popped as the DUT produces them.
  always @(negedge clk) if (mon_en) begin
    if (shift_en) begin
      chk("bits_pending", exp_bits.size() != 0, 1);
      if (exp_bits.size() != 0) chk("ser_out", ser_out, exp_bits.pop_front());
    end else chk("ser_out_idle", ser_out, 0);
    if (done) begin
      chk("words_pending", exp_words.size() != 0, 1);
      if (exp_words.size() != 0) chk("word_out", word_out, exp_words.pop_front());
    end
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    din = '0;
    step();
    step();
    chk("rst_ser", ser_out, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_word", word_out, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    run_txn(4'b1011, 1'b0);
    run_txn(4'b1011, 1'b1);
    run_txn(4'b0000, 1'b0);
    for (int t = 0; t < 3; t++) push_txn(4'b0110);
    start = 1'b1;
    din = 4'b0110;
    step();
    for (int i = 0; i < 3 * P; i++) begin
      if (i == 2 * P) start = 1'b0;
      chk("back_to_back_done", done, (i % P) == NB);
      step();
    end
    chk("back_to_back_idle", busy, 0);
    push_txn(4'b1011);
    start = 1'b1;
    din = 4'b1011;
    step();
    start = 1'b0;
    chk("abort_shift_en", shift_en, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_bits.delete();
    exp_words.delete();
    chk("abort_ser", ser_out, 0);
    chk("abort_shift_en_low", shift_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_word", word_out, 0);
    for (int i = 0; i < P; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_stays_idle", busy, 0);
      step();
    end
    run_txn(4'b0001, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    din = 4'b1011;
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_start_busy", busy, 0);
      chk("rst_start_shift_en", shift_en, 0);
      step();
    end
    chk("bits_left", exp_bits.size(), 0);
    chk("words_left", exp_words.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
